// File: rtl/bnn_pkg.sv
// Shared constants and state encoding for the binarized layer tail.
// Sizes match the next layer's xnor_popcount data path.
package bnn_pkg;

    // Packed activation word width
    localparam int WL   = 112;

    // Popcount / threshold width
    localparam int CW   = 7;

    // Bit counter width, wide enough to hold 0..WL
    localparam int CNTW = $clog2(WL + 1);

    // Packer states: accumulating bits, or holding a finished word
    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/binarize_cmp.sv
// Folded batch-norm comparator: popcount against threshold, with
// optional inversion for negative-gamma neurons. Purely combinational.
module binarize_cmp #(
    parameter int CW = 7
) (
    input  logic [CW-1:0] pop_i,
    input  logic [CW-1:0] thresh_i,
    input  logic          flip_i,
    output logic          bit_o
);

    logic ge;

    // Unsigned compare, then optional invert
    always_comb begin
        ge    = (pop_i >= thresh_i);
        bit_o = ge ^ flip_i;
    end

endmodule

// File: rtl/binarize_pack.sv
// Binarize popcounts and pack the resulting bits LSB-first into
// WL-bit words for the next layer, with one word of skid in acc.
module binarize_pack
    import bnn_pkg::*;
(
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iVALID,
    output logic            oREADY,
    input  logic [CW-1:0]   idata,
    input  logic [CW-1:0]   ithresh,
    input  logic            iFLIP,
    input  logic            iLAST,
    output logic            oVALID,
    input  logic            iREADY,
    output logic [WL-1:0]   odata,
    output logic [CNTW-1:0] oCOUNT,
    output logic            oLAST
);

    localparam logic [CNTW-1:0] CNT_LASTBIT = CNTW'(WL - 1);
    localparam logic [CNTW-1:0] CNT_FULL    = CNTW'(WL);
    localparam logic [CNTW-1:0] CNT_ONE     = CNTW'(1);

    state_e          state_q;
    logic [WL-1:0]   acc_q;
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] hcnt_q;
    logic            hlast_q;
    logic            valid_q;
    logic [WL-1:0]   data_q;
    logic [CNTW-1:0] count_q;
    logic            last_q;

    logic            act_bit;
    logic            accept;
    logic            close;
    logic            out_free;
    logic [WL-1:0]   bit_mask;
    logic [WL-1:0]   word_d;
    logic [CNTW-1:0] cnt_inc;

    binarize_cmp #(
        .CW(CW)
    ) u_cmp (
        .pop_i   (idata),
        .thresh_i(ithresh),
        .flip_i  (iFLIP),
        .bit_o   (act_bit)
    );

    assign oREADY = (state_q == ACC);
    assign oVALID = valid_q;
    assign odata  = data_q;
    assign oCOUNT = count_q;
    assign oLAST  = last_q;

    // Handshake qualifiers and the word including the incoming bit
    always_comb begin
        accept   = iVALID && oREADY;
        close    = accept && ((cnt_q == CNT_LASTBIT) || iLAST);
        out_free = !valid_q || iREADY;
        cnt_inc  = cnt_q + CNT_ONE;
        bit_mask = {{(WL-1){1'b0}}, act_bit} << cnt_q;
        word_d   = acc_q | bit_mask;
    end

    // Packer FSM with registered output word
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            hcnt_q  <= '0;
            hlast_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            if (valid_q && iREADY) begin
                valid_q <= 1'b0;
            end
            unique case (state_q)
                ACC: begin
                    if (accept) begin
                        if (close && out_free) begin
                            data_q  <= word_d;
                            count_q <= cnt_inc;
                            last_q  <= iLAST;
                            valid_q <= 1'b1;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                        end else if (close) begin
                            acc_q   <= word_d;
                            cnt_q   <= CNT_FULL;
                            hcnt_q  <= cnt_inc;
                            hlast_q <= iLAST;
                            state_q <= HOLD;
                        end else begin
                            acc_q   <= word_d;
                            cnt_q   <= cnt_inc;
                        end
                    end
                end
                HOLD: begin
                    if (out_free) begin
                        data_q  <= acc_q;
                        count_q <= hcnt_q;
                        last_q  <= hlast_q;
                        valid_q <= 1'b1;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        hlast_q <= 1'b0;
                        state_q <= ACC;
                    end
                end
                default: state_q <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_binarize_pack.sv
// Directed self-checking bench for binarize_pack.
// Inputs change 1 time unit after each rising edge.
module tb_binarize_pack;

    localparam int WL = 112;

    logic          iCLK = 1'b0;
    logic          iRST;
    logic          iVALID;
    logic          oREADY;
    logic [6:0]    idata;
    logic [6:0]    ithresh;
    logic          iFLIP;
    logic          iLAST;
    logic          oVALID;
    logic          iREADY;
    logic [WL-1:0] odata;
    logic [6:0]    oCOUNT;
    logic          oLAST;

    int checks   = 0;
    int failures = 0;

    logic [WL-1:0] ALL1;
    logic [WL-1:0] ALT;

    always #5 iCLK = ~iCLK;

    binarize_pack dut (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iVALID (iVALID),
        .oREADY (oREADY),
        .idata  (idata),
        .ithresh(ithresh),
        .iFLIP  (iFLIP),
        .iLAST  (iLAST),
        .oVALID (oVALID),
        .iREADY (iREADY),
        .odata  (odata),
        .oCOUNT (oCOUNT),
        .oLAST  (oLAST)
    );

    task automatic chk(input string tag, input logic [WL-1:0] obs,
                       input logic [WL-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic push(input logic [6:0] d, input logic [6:0] t,
                        input logic f, input logic l);
        iVALID  = 1'b1;
        idata   = d;
        ithresh = t;
        iFLIP   = f;
        iLAST   = l;
        step();
    endtask

    task automatic idle();
        iVALID = 1'b0;
        iLAST  = 1'b0;
        step();
    endtask

    // 49 vs 50 is below threshold; odd positions flip it to 1
    task automatic push_alt(input int i);
        push(7'd49, 7'd50, (i % 2) == 1, 1'b0);
    endtask

    initial begin
        ALL1    = '1;
        ALT     = {56{2'b10}};
        iRST    = 1'b1;
        iVALID  = 1'b0;
        idata   = '0;
        ithresh = '0;
        iFLIP   = 1'b0;
        iLAST   = 1'b0;
        iREADY  = 1'b1;
        step();
        step();
        iRST = 1'b0;
        chk("rst_valid", WL'(oVALID), WL'(0));
        chk("rst_ready", WL'(oREADY), WL'(1));
        chk("rst_data",  odata,       WL'(0));
        chk("rst_count", WL'(oCOUNT), WL'(0));
        chk("rst_last",  WL'(oLAST),  WL'(0));

        for (int i = 0; i < WL - 1; i++) push(7'd50, 7'd50, 1'b0, 1'b0);
        chk("stream_early", WL'(oVALID), WL'(0));
        push(7'd50, 7'd50, 1'b0, 1'b0);
        chk("stream_valid", WL'(oVALID), WL'(1));
        chk("stream_data",  odata,       ALL1);
        chk("stream_count", WL'(oCOUNT), WL'(112));
        chk("stream_last",  WL'(oLAST),  WL'(0));
        idle();
        chk("stream_drop",  WL'(oVALID), WL'(0));

        for (int i = 0; i < WL; i++) push_alt(i);
        chk("alt_valid", WL'(oVALID), WL'(1));
        chk("alt_data",  odata,       ALT);
        chk("alt_count", WL'(oCOUNT), WL'(112));
        idle();

        push(7'd50,  7'd50, 1'b0, 1'b0);
        push(7'd60,  7'd50, 1'b1, 1'b0);
        push(7'd49,  7'd50, 1'b1, 1'b0);
        push(7'd0,   7'd0,  1'b0, 1'b0);
        push(7'd127, 7'd3,  1'b0, 1'b1);
        chk("short_valid", WL'(oVALID), WL'(1));
        chk("short_data",  odata,       WL'(8'h1D));
        chk("short_count", WL'(oCOUNT), WL'(5));
        chk("short_last",  WL'(oLAST),  WL'(1));
        idle();

        push(7'd10, 7'd11, 1'b1, 1'b1);
        chk("one_data",  odata,       WL'(1));
        chk("one_count", WL'(oCOUNT), WL'(1));
        chk("one_last",  WL'(oLAST),  WL'(1));
        idle();

        iREADY = 1'b0;
        for (int i = 0; i < WL; i++) push(7'd50, 7'd50, 1'b0, 1'b0);
        for (int i = 0; i < WL; i++) push_alt(i);
        chk("bp_valid", WL'(oVALID), WL'(1));
        chk("bp_data1", odata,       ALL1);
        chk("bp_ready", WL'(oREADY), WL'(0));
        idle();
        chk("bp_stable", odata,       ALL1);
        chk("bp_cnt",    WL'(oCOUNT), WL'(112));
        chk("bp_hold",   WL'(oREADY), WL'(0));
        iREADY = 1'b1;
        idle();
        chk("bp_valid2", WL'(oVALID), WL'(1));
        chk("bp_data2",  odata,       ALT);
        chk("bp_ready2", WL'(oREADY), WL'(1));
        chk("bp_last2",  WL'(oLAST),  WL'(0));
        idle();
        chk("bp_drain",  WL'(oVALID), WL'(0));

        iREADY = 1'b0;
        for (int i = 0; i < WL; i++) push(7'd50, 7'd50, 1'b0, 1'b0);
        for (int i = 0; i < WL - 1; i++) push_alt(i);
        chk("b2b_pre",   WL'(oVALID), WL'(1));
        chk("b2b_old",   odata,       ALL1);
        iREADY = 1'b1;
        push_alt(WL - 1);
        chk("b2b_valid", WL'(oVALID), WL'(1));
        chk("b2b_data",  odata,       ALT);
        chk("b2b_ready", WL'(oREADY), WL'(1));
        idle();
        chk("b2b_drain", WL'(oVALID), WL'(0));

        iREADY = 1'b0;
        for (int i = 0; i < WL; i++) push(7'd50, 7'd50, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) push(7'd50, 7'd50, 1'b0, 1'b0);
        iRST = 1'b1;
        idle();
        iRST = 1'b0;
        chk("mrst_valid", WL'(oVALID), WL'(0));
        chk("mrst_data",  odata,       WL'(0));
        chk("mrst_count", WL'(oCOUNT), WL'(0));
        chk("mrst_last",  WL'(oLAST),  WL'(0));
        chk("mrst_ready", WL'(oREADY), WL'(1));
        iREADY = 1'b1;
        for (int i = 0; i < WL - 1; i++) push_alt(i);
        chk("mrst_early", WL'(oVALID), WL'(0));
        push_alt(WL - 1);
        chk("mrst_wvalid", WL'(oVALID), WL'(1));
        chk("mrst_wdata",  odata,       ALT);
        chk("mrst_wcount", WL'(oCOUNT), WL'(112));
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
